// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults for the multiplexed D flip-flop.
// Instances that do not override WIDTH/RESET_VAL pick these up, so every
// user of d_ff starts from the same width and reset value.
package d_ff_pkg;

  localparam int          DFF_WIDTH     = 1;   // default data width
  localparam int          DFF_WIDTH_MAX = 64;  // widest supported datapath
  localparam logic [63:0] DFF_RESET_VAL = '0;  // default reset value, truncated to WIDTH

endpackage

// File: rtl/d_ff_if.sv
// d_ff_if: data bundle of the multiplexed D flip-flop.
//   d0  : load source when sel=0
//   d1  : load source when sel=1
//   sel : source select
//   q   : registered output
// master drives d0/d1/sel and observes q; slave (the flop) is the reverse.
interface d_ff_if import d_ff_pkg::*; #(
  parameter int WIDTH = DFF_WIDTH
) ();

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             sel;
  logic [WIDTH-1:0] q;

  modport master (output d0, output d1, output sel, input  q);
  modport slave  (input  d0, input  d1, input  sel, output q);

endinterface

// File: rtl/d_ff_mux2.sv
// mux2: WIDTH-bit 2:1 select, y = s ? b : a.
//   a : selected when s=0
//   b : selected when s=1
//   s : select
//   y : result
// The conditional operator is used on purpose: an unknown s merges a and b
// bitwise (equal bits resolve, differing bits go X) instead of masking X.
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/d_ff.sv
// d_ff: 2:1 multiplexed D flip-flop with asynchronous active-low reset.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low; q = RESET_VAL while low
//   bus : d_ff_if slave port (d0, d1, sel in; q out)
// q loads (sel ? d1 : d0) on every rising edge; there is no enable, so
// holding a value means presenting q back on the selected input.
// WIDTH must match the width of the connected interface (1..64).
module d_ff import d_ff_pkg::*; #(
  parameter int               WIDTH     = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic  clk,
  input  logic  rst,
  d_ff_if.slave bus
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] q_r;

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .a (bus.d0),
    .b (bus.d1),
    .s (bus.sel),
    .y (nxt)
  );

  // Reset wins over a coincident clock edge; no power-up value is implied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_r <= RESET_VAL;
    else      q_r <= nxt;
  end

  assign bus.q = q_r;

  // Simulation checks: reset value is held while reset is low, and the
  // select is never unknown at a capturing edge.
  a_rst_val: assert property (@(posedge clk) !rst |-> (q_r == RESET_VAL));
  a_sel_known: assert property (@(posedge clk) rst |-> !$isunknown(bus.sel));

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed bench for d_ff. Expected q values are queued when the
// stimulus is driven and popped when q is sampled 5 units after the edge.
// Inputs are legal only 5 units either side of each rising edge, X otherwise.
module tb_d_ff;

  logic clk;
  logic rst1;
  logic rst8;

  d_ff_if #(.WIDTH(1)) b1 ();
  d_ff_if #(.WIDTH(8)) b8 ();

  d_ff #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8.slave)
  );

  // 100-unit period, rising edges at 50, 150, 250, ...
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic       sb1 [$];
  logic [7:0] sb8 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop1(input string tag);
    if (sb1.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0h expected queued value", tag, b1.q);
    end else begin
      chk(tag, 64'(b1.q), 64'(sb1.pop_front()));
    end
  endtask

  task automatic pop8(input string tag);
    if (sb8.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0h expected queued value", tag, b8.q);
    end else begin
      chk(tag, 64'(b8.q), 64'(sb8.pop_front()));
    end
  endtask

  // Drive at edge-5, check at edge+5, then let the inputs go X.
  task automatic step1(input logic r, input logic a, input logic b, input logic s,
                       input logic e, input string tag);
    @(negedge clk);
    #45;
    rst1 = r; b1.d0 = a; b1.d1 = b; b1.sel = s;
    sb1.push_back(e);
    @(posedge clk);
    #5;
    pop1(tag);
    b1.d0 = 1'bx; b1.d1 = 1'bx; b1.sel = 1'bx;
  endtask

  task automatic step8(input logic r, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] e, input string tag);
    @(negedge clk);
    #45;
    rst8 = r; b8.d0 = a; b8.d1 = b; b8.sel = s;
    sb8.push_back(e);
    @(posedge clk);
    #5;
    pop8(tag);
  endtask

  initial begin
    logic a, b, s, e;
    rst1 = 1'b1;
    rst8 = 1'b1;
    b1.d0 = 1'bx; b1.d1 = 1'bx; b1.sel = 1'bx;
    b8.d0 = 8'h00; b8.d1 = 8'h00; b8.sel = 1'b0;

    // 8-bit flop parked in reset while the 1-bit flop is exercised.
    #5 rst8 = 1'b0;

    // Asynchronous reset: q clears before any clock edge.
    #5;
    rst1 = 1'b0; b1.d0 = 1'b1; b1.d1 = 1'b1; b1.sel = 1'($urandom_range(0, 1));
    sb1.push_back(1'b0);
    #1 pop1("rst_async");

    // Reset held across a rising edge with both data inputs high.
    step1(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "rst_edge");

    // Load from d0.
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "ld_d0_0");
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ld_d0_1");

    // Load from d1.
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "ld_d1_1");
    step1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "ld_d1_0");

    // Sequence: reset, d1(1), d0(1), d1(0), d0(1), reset.
    step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "seq_rst_a");
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "seq_d1_1");
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "seq_d0_1");
    step1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "seq_d1_0");
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "seq_d0_1b");
    step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "seq_rst_b");

    // Random legal loads with X between windows; q must stay known mid-cycle.
    for (int i = 0; i < 4; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      e = s ? b : a;
      step1(1'b1, a, b, s, e, "xwin_edge");
      @(negedge clk);
      n_checks++;
      assert (!$isunknown(b1.q)) else begin
        n_fail++;
        $error("FAIL xwin_known: observed %b expected known value", b1.q);
      end
      sb1.push_back(e);
      pop1("xwin_mid");
    end

    // Mid-cycle reset while q=1: clears immediately, no edge needed.
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "mid_pre");
    #20;
    rst1 = 1'b0;
    sb1.push_back(1'b0);
    #1 pop1("mid_rst");

    // Release and reload after the mid-cycle reset.
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "mid_post");
    rst1 = 1'b0;

    // 8-bit instance with RESET_VAL=A5.
    step8(1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, "w8_rst");
    step8(1'b1, 8'h3C, 8'h00, 1'b0, 8'h3C, "w8_d0");
    step8(1'b1, 8'h00, 8'hC3, 1'b1, 8'hC3, "w8_d1");
    step8(1'b1, 8'hxx, 8'h5A, 1'b1, 8'h5A, "w8_unsel_x");
    rst8 = 1'b0;
    sb8.push_back(8'hA5);
    #1 pop8("w8_async_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_ff.md
# d_ff

Single-bit-wide by default, parameterizable 2:1 multiplexed D flip-flop. On each rising clock edge it registers one of two data inputs, selected by `sel`. An asynchronous active-low reset forces the output to its reset value. It is a leaf storage primitive for datapaths that need a selectable load source without an external mux.

## Interface
- `WIDTH`, default 1: data width of `d0`, `d1`, `q`; legal range 1..64.
- `RESET_VAL`, default 0 (WIDTH bits): value forced onto `q` during reset.

Ports:
- `clk` input 1: clock, rising-edge active; one clock domain only.
- `rst` input 1: reset, asynchronous and active-low (asserted at 0); `q` = `RESET_VAL` while low.
- `d0` input WIDTH: data loaded when `sel`=0.
- `d1` input WIDTH: data loaded when `sel`=1.
- `sel` input 1: source select; 0 picks `d0`, 1 picks `d1`.
- `q` output WIDTH: registered output.

## Operation
- Next-state value = `sel ? d1 : d0`, computed combinationally. It is captured into `q` on each `clk` rising edge while `rst`=1.
- `rst`=0: `q` goes to `RESET_VAL` immediately, with no clock required. It holds there regardless of `clk`, `sel`, `d0`, `d1`.
- `rst` deassertion (0→1) is asynchronous to the register. The first load occurs on the first rising `clk` edge after `rst` is high. Integrators must deassert `rst` with at least the register's recovery time before that edge.
- Reset has priority over a simultaneous clock edge: `rst`=0 at a rising edge gives `q`=`RESET_VAL`.
- There is no enable. `q` reloads on every edge, so the holding value requires `d0`/`d1` to present `q`.
- X/Z propagation in simulation: an X on the selected data input propagates into `q`. An X on `sel` yields standard ternary-merge semantics (bits equal in `d0`/`d1` resolve; differing bits become X). No masking of unknowns.
- Reset is not applied at power-up. `q` is X until the first reset or the first clocked load with known inputs.

## Timing
- Latency: 1 clock. `q` reflects the inputs sampled at rising edge N from edge N until edge N+1.
- Reset assertion latency: combinational (0 cycles) from the `rst` falling edge to `q`=`RESET_VAL`.
- `d0`, `d1` and `sel` must meet setup/hold around the rising `clk` edge. The bench uses 5 time-unit setup and 5 time-unit hold at a 100 time-unit period, and inputs may be X outside that window.
- No combinational path from any input to `q` except the `rst` assertion.

## Structure
- Shared package `d_ff_pkg`: default `WIDTH` and `RESET_VAL` constants, so users instantiate with consistent defaults.
- Sub-module `mux2` (parameter WIDTH; ports `a`, `b`, `s`, `y`): the select logic, instantiated once. The register process in `d_ff` contains only the async reset and the clocked load.
- Embedded assertions (simulation only):
  - `q`==`RESET_VAL` whenever `rst`==0.
  - `sel` is known at every rising edge while `rst`==1.

## Test plan
- Reset with d0=1, d1=1, sel random: hold `rst`=0 across a rising edge, check 5 units after the edge → `q`=0. Also check `q`=0 before any clock edge after `rst` falls, which proves asynchronous behaviour.
- Load d0: `rst`=1, d0=0, d1=1, sel=0 → `q`=0 after edge. Repeat with d0=1, d1=0 → `q`=1.
- Load d1: `rst`=1, d0=0, d1=1, sel=1 → `q`=1. Then d0=1, d1=0, sel=1 → `q`=0.
- Sequence reset, d1(1), d0(1), d1(0), d0(1), reset → `q` = 0, 1, 1, 0, 1, 0 on consecutive checks.
- Inputs X between setup/hold windows, with legal values driven 5 units around each edge → `q` never X after the first reset. Then assert `rst`=0 mid-cycle (between edges) while `q`=1 → `q`=0 immediately.
- `WIDTH`=8, `RESET_VAL`=8'hA5: reset → `q`=8'hA5. Then sel=0, d0=8'h3C → `q`=8'h3C. Then sel=1, d1=8'hC3 → `q`=8'hC3.
